// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexes four 5-bit display codes onto a shared
// segment decoder input (digit_code) and a 4-bit active-low anode bus (an).
// Incoming codes land in a shadow buffer and are copied to the active set only
// at the frame boundary, so a frame never tears. Each digit slot starts with
// GAP_CYCLES blanked cycles to suppress ghosting.
// Optional build macro DISPLAY_SCAN_LEADING_ZERO_BLANK_EN: blank leading zeros
// of digits 3..1 during the shadow-to-active copy.
module display_scan_mux #(
    parameter int REFRESH_DIV = 100000,  // cycles per digit slot, >= 2
    parameter int GAP_CYCLES  = 16       // blanked cycles per slot, < REFRESH_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [19:0] digits_in,
    output logic [4:0]  digit_code,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int              CW       = $clog2(REFRESH_DIV);
    localparam logic [4:0]      BLANK    = 5'd17;
    localparam bit              HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   GAP_LAST = CW'(HAS_GAP ? GAP_CYCLES - 1 : 0);

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam state_t SLOT_START = HAS_GAP ? GAP : SHOW;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      idx, idx_nxt;
    logic [3:0][4:0] shadow;
    logic [3:0][4:0] active, active_nxt;
    logic            slot_end;
    logic            frame_end;

    // Clamp every field above 17 to the blank code.
    function automatic logic [3:0][4:0] sanitise(input logic [19:0] raw);
        logic [3:0][4:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i] = (raw[i*5 +: 5] > BLANK) ? BLANK : raw[i*5 +: 5];
        end
        return res;
    endfunction

`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
    // Blank leading zeros from digit 3 downward; digit 0 always shows.
    // A blank digit keeps the chain going, any other non-zero code ends it.
    function automatic logic [3:0][4:0] frame_copy(input logic [3:0][4:0] d);
        logic [3:0][4:0] res;
        logic            chain;
        res   = d;
        chain = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (chain) begin
                if (d[i] == 5'd0) begin
                    res[i] = BLANK;
                end else if (d[i] != BLANK) begin
                    chain = 1'b0;
                end
            end
        end
        return res;
    endfunction
`else
    // Codes are copied verbatim; zeros display as 0.
    function automatic logic [3:0][4:0] frame_copy(input logic [3:0][4:0] d);
        return d;
    endfunction
`endif

    // Next-state logic for slot counter, slot index, FSM and active digits.
    always_comb begin
        slot_end   = (cnt == CNT_LAST);
        frame_end  = slot_end && (idx == 2'd3);
        cnt_nxt    = cnt + 1'b1;
        idx_nxt    = idx;
        state_nxt  = state;
        active_nxt = frame_end ? frame_copy(shadow) : active;
        if (slot_end) begin
            cnt_nxt   = '0;
            idx_nxt   = idx + 2'd1;
            state_nxt = SLOT_START;
        end else if (state == GAP && cnt == GAP_LAST) begin
            state_nxt = SHOW;
        end
    end

    // State, buffers and registered outputs, all updated on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values computed by the comb block.
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            state      <= SLOT_START;
            // NOTE: the digit buffers are reset explicitly because the display
            // must stay blank until a load has reached the active set.
            shadow     <= {4{BLANK}};
            active     <= {4{BLANK}};
            an         <= 4'b1111;
            digit_code <= BLANK;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            state      <= state_nxt;
            active     <= active_nxt;
            frame_tick <= frame_end;
            if (load) begin
                shadow <= sanitise(digits_in);
            end
            if (state_nxt == SHOW) begin
                an         <= ~(4'b0001 << idx_nxt);
                digit_code <= active_nxt[idx_nxt];
            end else begin
                an         <= 4'b1111;
                digit_code <= BLANK;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Testbench for display_scan_mux. Two instances share stimulus: dut_a with
// REFRESH_DIV=8, GAP_CYCLES=2 and dut_b with REFRESH_DIV=8, GAP_CYCLES=0.
// Frame-level vectors list the loads issued during a frame and the digits
// expected on screen during that same frame.
module tb_display_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [19:0] digits_in;
    logic [4:0]  code_a, code_b;
    logic [3:0]  an_a, an_b;
    logic        tick_a, tick_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    display_scan_mux #(.REFRESH_DIV(8), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
        .digit_code(code_a), .an(an_a), .frame_tick(tick_a)
    );

    display_scan_mux #(.REFRESH_DIV(8), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
        .digit_code(code_b), .an(an_b), .frame_tick(tick_b)
    );

    typedef struct {
        logic [19:0] ld_a;   // first load value
        int          at_a;   // frame cycle of first load, -1 = none
        logic [19:0] ld_b;   // second load value
        int          at_b;   // frame cycle of second load, -1 = none
        logic [19:0] exp;    // digits expected during this frame
    } frame_vec_t;

    frame_vec_t vecs[10];

    function automatic logic [19:0] d4(input int a3, input int a2, input int a1, input int a0);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until dut_a pulses frame_tick, bounded; returns steps taken.
    task automatic wait_tick(output int n);
        n = 0;
        while (!tick_a && n < 100) begin
            step();
            n++;
        end
    endtask

    // Called while sampling frame cycle 0 (frame_tick high); checks 32 cycles.
    task automatic check_frame(input int f, input frame_vec_t v);
        int         s;
        logic [4:0] dc;
        logic [9:0] ea, eb;
        for (int k = 0; k < 32; k++) begin
            s  = k / 8;
            dc = v.exp[s*5 +: 5];
            if (k % 8 < 2) ea = {4'b1111, 5'd17, (k == 0)};
            else           ea = {~(4'b0001 << s), dc, 1'b0};
            eb = {~(4'b0001 << s), dc, (k == 0)};
            check($sformatf("frame%0d k%0d gap2", f, k), {22'd0, an_a, code_a, tick_a}, {22'd0, ea});
            check($sformatf("frame%0d k%0d gap0", f, k), {22'd0, an_b, code_b, tick_b}, {22'd0, eb});
            load      = (k == v.at_a) || (k == v.at_b);
            digits_in = (k == v.at_b) ? v.ld_b : v.ld_a;
            step();
        end
        load = 1'b0;
    endtask

    initial begin
        int         n;
        frame_vec_t blank_vec;

        // Basic scan, tear-free update, load/boundary collision.
        vecs[0] = '{d4(0,0,0,0),    -1, d4(0,0,0,0), -1, d4(4,3,2,1)};
        vecs[1] = '{d4(9,9,9,9),    19, d4(0,0,0,0), -1, d4(4,3,2,1)};
        vecs[2] = '{d4(5,6,7,8),    31, d4(0,0,0,0), -1, d4(9,9,9,9)};
        vecs[3] = '{d4(0,0,0,0),    -1, d4(0,0,0,0), -1, d4(9,9,9,9)};
        // Sanitising: 31, 18, 25 clamp to 17; 16 passes.
        vecs[4] = '{d4(16,18,25,31),  5, d4(0,0,0,0), -1, d4(5,6,7,8)};
        // Back-to-back loads: the second one wins.
        vecs[5] = '{d4(1,1,1,1),      3, d4(0,0,5,0),  4, d4(16,17,17,17)};
        vecs[6] = '{d4(0,0,0,0),     10, d4(0,0,0,0), -1, d4(0,0,0,0)};
        vecs[7] = '{d4(17,0,0,3),    10, d4(0,0,0,0), -1, d4(0,0,0,0)};
        vecs[8] = '{d4(16,0,0,0),    10, d4(0,0,0,0), -1, d4(0,0,0,0)};
        vecs[9] = '{d4(0,0,0,0),     -1, d4(0,0,0,0), -1, d4(16,0,0,0)};
`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
        vecs[6].exp = d4(17,17,5,0);
        vecs[7].exp = d4(17,17,17,0);
        vecs[8].exp = d4(17,17,17,3);
`else
        vecs[6].exp = d4(0,0,5,0);
        vecs[7].exp = d4(0,0,0,0);
        vecs[8].exp = d4(17,0,0,3);
`endif
        blank_vec = '{d4(0,0,0,0), -1, d4(0,0,0,0), -1, d4(17,17,17,17)};

        // Reset held for 3 cycles.
        rst       = 1'b1;
        load      = 1'b0;
        digits_in = '0;
        repeat (3) step();
        check("reset gap2", {22'd0, an_a, code_a, tick_a}, {22'd0, 4'b1111, 5'd17, 1'b0});
        check("reset gap0", {22'd0, an_b, code_b, tick_b}, {22'd0, 4'b1111, 5'd17, 1'b0});
        rst = 1'b0;

        // Cycle 1 still in gap, cycle 2 is the first lit slot (still blank code).
        step();
        check("cycle1 gap", {22'd0, an_a, code_a, tick_a}, {22'd0, 4'b1111, 5'd17, 1'b0});
        step();
        check("cycle2 show gap2", {22'd0, an_a, code_a, tick_a}, {22'd0, 4'b1110, 5'd17, 1'b0});
        check("cycle2 show gap0", {22'd0, an_b, code_b, tick_b}, {22'd0, 4'b1110, 5'd17, 1'b0});

        // Load the first value during cycle 2; first frame_tick is at cycle 32.
        load      = 1'b1;
        digits_in = d4(4,3,2,1);
        step();
        load = 1'b0;
        wait_tick(n);
        check("first tick delay", n, 29);
        check("first tick both", {30'd0, tick_a, tick_b}, 32'd3);

        for (int f = 0; f < 10; f++) begin
            check_frame(f, vecs[f]);
        end

        // Reset mid-frame discards both buffers and restarts the frame.
        repeat (13) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midreset gap2", {22'd0, an_a, code_a, tick_a}, {22'd0, 4'b1111, 5'd17, 1'b0});
        check("midreset gap0", {22'd0, an_b, code_b, tick_b}, {22'd0, 4'b1111, 5'd17, 1'b0});
        wait_tick(n);
        check("midreset tick delay", n, 32);
        check_frame(10, blank_vec);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
